// File: rtl/instr_mem_if.sv
// Fetch-side memory bus: address-valid request from the requester,
// one-cycle data-valid response from the memory.
interface instr_mem_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) ();

  logic                     i_addr_valid;
  logic [ADDRESS_WIDTH-1:0] i_addr;
  logic                     o_mem_valid;
  logic [DATA_WIDTH-1:0]    o_mem_data;
  logic                     o_mem_err;

  // Requester side (fetch unit, loader, testbench).
  modport master (
    output i_addr_valid,
    output i_addr,
    input  o_mem_valid,
    input  o_mem_data,
    input  o_mem_err
  );

  // Responder side (the memory).
  modport slave (
    input  i_addr_valid,
    input  i_addr,
    output o_mem_valid,
    output o_mem_data,
    output o_mem_err
  );

endinterface

// File: rtl/instr_mem.sv
// Word-addressed instruction/data memory. Serves one outstanding read at a
// time with a fixed, programmable latency; a separate write port updates the
// array independently of the read FSM. Word 0 holds the boot PC.
module instr_mem #(
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned LATENCY       = 2,   // 1..15
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  instr_mem_if.slave               bus,
  input  logic                     i_wr_en,
  input  logic [ADDRESS_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]    i_wr_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough to compare any address against DEPTH without truncation.
  localparam int unsigned CMP_W = ADDRESS_WIDTH + 33;
  localparam logic [3:0]  CNT_RELOAD = 4'(LATENCY - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic [1:0]               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                     enter_resp;

  logic                     valid_q, valid_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     err_q, err_d;

  function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
    return CMP_W'(a) < CMP_W'(DEPTH);
  endfunction

  // Write-first: a write landing on the same edge is visible to the read.
  function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDRESS_WIDTH-1:0] a);
    if (i_wr_en && (i_wr_addr == a)) begin
      return i_wr_data;
    end
    return mem[a[IDX_W-1:0]];
  endfunction

  // Array write port; not reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (i_wr_en && in_range(i_wr_addr)) begin
      mem[i_wr_addr[IDX_W-1:0]] <= i_wr_data;
    end
  end

  // Read FSM next-state: request latch, latency countdown, abort/restart.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.i_addr_valid) begin
          req_addr_d = bus.i_addr;
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = CNT_RELOAD;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!bus.i_addr_valid) begin
          state_d = StIdle;
        end else if (bus.i_addr != req_addr_q) begin
          req_addr_d = bus.i_addr;
          cnt_d      = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end
        end
      end
      StResp: state_d = StDone;
      StDone: begin
        if (!bus.i_addr_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Response outputs are only non-zero in the cycle following RESP entry.
  always_comb begin
    valid_d = enter_resp;
    data_d  = '0;
    err_d   = 1'b0;
    if (enter_resp) begin
      if (in_range(req_addr_d)) begin
        data_d = rd_word(req_addr_d);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and registered outputs; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      req_addr_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_mem_valid = valid_q;
  assign bus.o_mem_data  = data_q;
  assign bus.o_mem_err   = err_q;

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem: table-driven reads against a LATENCY=2 instance with a
// response scoreboard, plus latency sweep, abort/restart, boundary, forwarding
// and reset sequences.
module tb_instr_mem;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          wr_en   = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  logic          s_valid = 1'b0;
  logic [AW-1:0] s_addr  = '0;

  instr_mem_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();
  instr_mem_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) s1_if ();
  instr_mem_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) s3_if ();
  instr_mem_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) s15_if ();

  assign s1_if.i_addr_valid  = s_valid;
  assign s1_if.i_addr        = s_addr;
  assign s3_if.i_addr_valid  = s_valid;
  assign s3_if.i_addr        = s_addr;
  assign s15_if.i_addr_valid = s_valid;
  assign s15_if.i_addr       = s_addr;

  instr_mem #(.DEPTH(DEPTH), .LATENCY(LAT), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .bus(m_if),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );
  instr_mem #(.DEPTH(DEPTH), .LATENCY(1), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut_l1 (
    .clk(clk), .reset(reset), .bus(s1_if),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );
  instr_mem #(.DEPTH(DEPTH), .LATENCY(3), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut_l3 (
    .clk(clk), .reset(reset), .bus(s3_if),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );
  instr_mem #(.DEPTH(DEPTH), .LATENCY(15), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut_l15 (
    .clk(clk), .reset(reset), .bus(s15_if),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;
  exp_t sbq[$];

  logic [DW-1:0] model [DEPTH];

  // Scoreboard monitor on the main instance.
  always @(negedge clk) begin
    exp_t e;
    if (m_if.o_mem_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        check("resp_cycle", 64'(cyc), 64'(e.due));
        check("resp_data", 64'(m_if.o_mem_data), 64'(e.data));
        check("resp_err", 64'(m_if.o_mem_err), 64'(e.err));
      end
    end else begin
      check("idle_outputs", 64'({m_if.o_mem_valid, m_if.o_mem_err, m_if.o_mem_data}), 64'd0);
    end
  end

  // Pulse recorders for the latency sweep instances.
  int            p_cnt  [3] = '{0, 0, 0};
  int unsigned   p_cyc  [3] = '{0, 0, 0};
  logic [DW-1:0] p_data [3];
  always @(negedge clk) begin
    if (s1_if.o_mem_valid === 1'b1) begin
      p_cnt[0]++; p_cyc[0] = cyc; p_data[0] = s1_if.o_mem_data;
    end
    if (s3_if.o_mem_valid === 1'b1) begin
      p_cnt[1]++; p_cyc[1] = cyc; p_data[1] = s3_if.o_mem_data;
    end
    if (s15_if.o_mem_valid === 1'b1) begin
      p_cnt[2]++; p_cyc[2] = cyc; p_data[2] = s15_if.o_mem_data;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a held read from a negedge; expect one response LAT cycles later.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e,
                         input int hold);
    m_if.i_addr       = a;
    m_if.i_addr_valid = 1'b1;
    sbq.push_back('{due: cyc + LAT, data: d, err: e});
    step(int'(LAT) + hold);
    m_if.i_addr_valid = 1'b0;
    step(2);
    check("missing_resp", 64'(sbq.size()), 64'd0);
  endtask

  // Fetch-style request: drop valid in the response cycle.
  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen;
    seen = 1'b0;
    m_if.i_addr       = a;
    m_if.i_addr_valid = 1'b1;
    sbq.push_back('{due: cyc + LAT, data: d, err: 1'b0});
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (m_if.o_mem_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    m_if.i_addr_valid = 1'b0;
    check("fetch_resp_seen", 64'(seen), 64'd1);
    step(2);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } vec_t;
  vec_t vecs [6];

  initial begin
    int unsigned c;
    vecs[0] = '{addr: 8'd0,   data: 32'h0000_0100, err: 1'b0};
    vecs[1] = '{addr: 8'd3,   data: 32'hA000_0033, err: 1'b0};
    vecs[2] = '{addr: 8'd15,  data: 32'hA000_00FF, err: 1'b0};
    vecs[3] = '{addr: 8'd16,  data: 32'h0,         err: 1'b1};
    vecs[4] = '{addr: 8'd200, data: 32'h0,         err: 1'b1};
    vecs[5] = '{addr: 8'd1,   data: 32'hA000_0011, err: 1'b0};

    m_if.i_addr_valid = 1'b0;
    m_if.i_addr       = '0;
    reset             = 1'b1;
    step(1);

    // Preload while reset is held: writes must still land.
    for (int i = 0; i < int'(DEPTH); i++) begin
      model[i] = (i == 0) ? 32'h0000_0100 : 32'hA000_0000 + 32'(i) * 32'h11;
      wr_en    = 1'b1;
      wr_addr  = AW'(i);
      wr_data  = model[i];
      step(1);
    end
    wr_en = 1'b0;
    check("reset_valid", 64'(m_if.o_mem_valid), 64'd0);
    check("reset_data", 64'(m_if.o_mem_data), 64'd0);
    check("reset_err", 64'(m_if.o_mem_err), 64'd0);
    check("reset_valid_l15", 64'(s15_if.o_mem_valid), 64'd0);
    reset = 1'b0;
    step(1);

    // Table-driven reads, each held well past the response.
    for (int i = 0; i < 6; i++) begin
      do_read(vecs[i].addr, vecs[i].data, vecs[i].err, 4);
    end

    // Boot PC fetch, then a back-to-back fetch at minimum spacing.
    fetch(8'd0, model[0]);
    fetch(8'd15, model[15]);

    // Latency sweep on shared stimulus.
    c       = cyc;
    s_addr  = 8'd5;
    s_valid = 1'b1;
    step(20);
    s_valid = 1'b0;
    step(2);
    check("sweep_l1_count", 64'(p_cnt[0]), 64'd1);
    check("sweep_l1_cycle", 64'(p_cyc[0]), 64'(c + 1));
    check("sweep_l1_data", 64'(p_data[0]), 64'(model[5]));
    check("sweep_l3_count", 64'(p_cnt[1]), 64'd1);
    check("sweep_l3_cycle", 64'(p_cyc[1]), 64'(c + 3));
    check("sweep_l3_data", 64'(p_data[1]), 64'(model[5]));
    check("sweep_l15_count", 64'(p_cnt[2]), 64'd1);
    check("sweep_l15_cycle", 64'(p_cyc[2]), 64'(c + 15));
    check("sweep_l15_data", 64'(p_data[2]), 64'(model[5]));

    // Abort mid-WAIT: no response may appear.
    m_if.i_addr       = 8'd2;
    m_if.i_addr_valid = 1'b1;
    step(1);
    m_if.i_addr_valid = 1'b0;
    step(6);
    do_read(8'd2, model[2], 1'b0, 3);

    // Restart: address changes 2 -> 5 while waiting.
    m_if.i_addr       = 8'd2;
    m_if.i_addr_valid = 1'b1;
    step(1);
    m_if.i_addr = 8'd5;
    sbq.push_back('{due: cyc + LAT, data: model[5], err: 1'b0});
    step(int'(LAT) + 3);
    m_if.i_addr_valid = 1'b0;
    step(2);
    check("restart_resp", 64'(sbq.size()), 64'd0);

    // Out-of-range write must not touch the array.
    wr_en   = 1'b1;
    wr_addr = 8'd16;
    wr_data = 32'hDEAD_BEEF;
    step(1);
    wr_en = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_read(AW'(i), model[i], 1'b0, 1);
    end

    // Same-edge write to the request address at RESP entry is forwarded.
    m_if.i_addr       = 8'd7;
    m_if.i_addr_valid = 1'b1;
    sbq.push_back('{due: cyc + LAT, data: 32'h1234_5678, err: 1'b0});
    step(int'(LAT) - 1);
    wr_en    = 1'b1;
    wr_addr  = 8'd7;
    wr_data  = 32'h1234_5678;
    model[7] = 32'h1234_5678;
    step(1);
    wr_en = 1'b0;
    step(3);
    m_if.i_addr_valid = 1'b0;
    step(2);
    check("forward_resp", 64'(sbq.size()), 64'd0);
    do_read(8'd7, model[7], 1'b0, 2);

    // Reset mid-WAIT with the request held; reissued after reset.
    m_if.i_addr       = 8'd9;
    m_if.i_addr_valid = 1'b1;
    step(1);
    reset = 1'b1;
    step(3);
    check("reset_mid_valid", 64'(m_if.o_mem_valid), 64'd0);
    reset = 1'b0;
    sbq.push_back('{due: cyc + LAT, data: model[9], err: 1'b0});
    step(int'(LAT) + 3);
    m_if.i_addr_valid = 1'b0;
    step(2);
    check("reset_reissue_resp", 64'(sbq.size()), 64'd0);
    do_read(8'd0, model[0], 1'b0, 2);

    check("final_queue_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
# instr_mem

Word-addressed instruction/data memory that acts as the responder on the fetch-side memory interface (address-valid request in, data-valid response out). It services one outstanding read at a time with a programmable fixed latency, and takes a separate single-cycle write port used by the loader and testbenches. Word 0 holds the initial PC, which the fetch unit reads after reset.

## Interface
- `DEPTH`, default 256: number of `DATA_WIDTH` words stored. Addresses are word indices.
- `LATENCY`, default 2, legal range 1–15: cycles from request sample to response.
- `clk` in, 1: single clock, rising edge.
- `reset` in, 1: synchronous, active-high.
- `i_addr_valid` in, 1: read request is held valid by the requester.
- `i_addr` in, `ADDRESS_WIDTH`: read word address, meaningful only while `i_addr_valid` is high.
- `o_mem_valid` out, 1: one-cycle response strobe.
- `o_mem_data` out, `DATA_WIDTH`: read data, meaningful only while `o_mem_valid` is high.
- `o_mem_err` out, 1: out-of-range address flag, qualified by `o_mem_valid`.
- `i_wr_en` in, 1: write strobe.
- `i_wr_addr` in, `ADDRESS_WIDTH`: write word address.
- `i_wr_data` in, `DATA_WIDTH`: write data.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: latency countdown.
  - RESP: response cycle.
  - DONE: waiting for the requester to drop the request.
- IDLE: at an edge with `i_addr_valid`=1, latch `i_addr` as `req_addr`.
  - If `LATENCY`=1, go to RESP.
  - Otherwise load the counter with `LATENCY`-1 and go to WAIT.
- WAIT, evaluated at each edge in this order:
  1. `i_addr_valid`=0: abort to IDLE. No response is produced.
  2. `i_addr` differs from `req_addr`: relatch the address, reload the counter with `LATENCY`-1, stay in WAIT. The request restarts.
  3. Otherwise decrement the counter. When it reaches 0, go to RESP.
- Entry to RESP: `o_mem_data` and `o_mem_err` are registered from `req_addr`.
  - `req_addr` < `DEPTH`: `o_mem_data` = `mem[req_addr]`, `o_mem_err`=0.
  - `req_addr` >= `DEPTH`: `o_mem_data`=0, `o_mem_err`=1. No wrap-around or aliasing.
- RESP: `o_mem_valid`=1 for exactly one cycle, then go to DONE.
- DONE: stay until an edge samples `i_addr_valid`=0, then go to IDLE.
  - A level-held request therefore never produces a second response.
  - The fetch unit drops `i_addr_valid` on the edge where it sees `o_mem_valid`, so DONE normally lasts one cycle.
- Writes:
  - Independent of the read FSM, in any state including during reset.
  - `mem[i_wr_addr]` = `i_wr_data` at an edge with `i_wr_en`=1.
  - Out-of-range write addresses are ignored.
- Write/read collision: a write at the same edge that enters RESP, to `req_addr`, is forwarded. The response carries the new data (write-first).
- Outside RESP: `o_mem_data`=0 and `o_mem_err`=0.
- Reset:
  - Outputs: `o_mem_valid`=0, `o_mem_data`=0, `o_mem_err`=0.
  - FSM goes to IDLE and the counter clears.
  - An in-flight request is dropped silently.
  - Memory contents are preserved. Reset does not clear the array.
  - A request held high through reset is sampled as new at the first edge with `reset`=0.

## Timing
- Let E0 be the first edge at which IDLE samples `i_addr_valid`=1. Edges are counted from E0 as E0, E1, …
- `o_mem_valid` is high during the cycle after edge E(`LATENCY`-1). Response is `LATENCY` cycles after the request becomes visible.
- All outputs are registered. There is no combinational path from any input to any output.
- Minimum request spacing is `LATENCY`+2 cycles (request, RESP, DONE/deassert).
- Read data reflects array contents as of the RESP-entry edge, including a same-edge write.

## Test plan
- Basic read, `DEPTH`=16, `LATENCY`=2:
  - Preload `mem[0]`=32'h0000_0100.
  - Raise `i_addr_valid` with addr 0 and sample it at E0.
  - Required: `o_mem_valid` high only during the cycle after E1, data 32'h100, `o_mem_err`=0, no second pulse while the request stays held.
- Fetch handshake: connect to fetch and release `reset`. The fetch unit prints PC 100 and the responder returns to IDLE.
- Latency sweep over `LATENCY`=1, 3, 15: valid pulse exactly `LATENCY` cycles after E0, width 1 cycle.
- Abort and restart:
  - Abort: drop the request mid-WAIT. Required: no pulse, IDLE.
  - Restart: change addr 2→5 in WAIT. Required: the pulse arrives `LATENCY` cycles after the change and carries `mem[5]`.
- Boundaries:
  - Read addr 15: returns `mem[15]`.
  - Read addr 16: data 0, `o_mem_err`=1.
  - Write addr 16: no array word changes.
  - Same-edge write to `req_addr` at RESP entry: the response returns the new value.
- Reset mid-WAIT: no pulse, outputs 0, `mem` retained. A held request is reissued after reset deasserts and returns correct data `LATENCY` cycles later.
